line_window_gen: RTL and testbench
==================================

# line_window_gen

Parametrised sliding-window generator with internal zero-padding, stride selection and valid/ready flow control on both sides. It accepts one raster-order pixel stream per frame and emits K×K windows only at legal output positions. It replaces the fixed 3×3, always-valid-after-fill window FIFO in front of the depthwise and standard convolution PEs.

## Interface
- IMG_W, 224: real image width in pixels
- IMG_H, 224: real image height in pixels
- K, 3: window size; odd, 3..7
- PAD, 1: zero border width on every side; 0..(K-1)/2
- STRIDE, 1: output stride on both axes; 1 or 2
- DATA_W, 14: pixel width, signed Q(DATA_W-7).7, passed through unmodified
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- in_pixel  in  DATA_W  real pixel, raster order, no padding included
- in_valid  in  1  in_pixel valid
- in_ready  out  1  block accepts in_pixel this cycle
- win_data  out  DATA_W*K*K  window; slice [DATA_W*(r*K+c) +: DATA_W] is window row r (0 = top), column c (0 = left)
- win_valid  out  1  win_data valid
- win_ready  in  1  downstream accepts window
- frame_done  out  1  one-cycle pulse after the last padded position of a frame

## Operation
- Padded frame: PW = IMG_W+2·PAD, PH = IMG_H+2·PAD. Counters col (0..PW-1) and row (0..PH-1) track the next padded position. Widths are $clog2 of the range.
- Position is padding if col<PAD, col≥PAD+IMG_W, row<PAD or row≥PAD+IMG_H.
- Shift register of depth (K-1)·PW+K, DATA_W each, newest at index 0.
- advance = !(win_valid && !win_ready).
- step = advance && state==ACTIVE/IDLE && (padding position || in_valid).
- On a padding step, 0 is shifted in and no input is consumed.
- On a real step, in_pixel is shifted in, and in_ready is high in the same cycle. in_ready = advance && !padding position.
- On each step, col increments. At PW-1, col wraps to 0 and row increments. At (PW-1, PH-1), both wrap to 0.
- Window tap (r,c) = shreg[(K-1-r)·PW + (K-1-c)]; win_data is driven combinationally from the taps.
- A step at position (row,col) produces a window iff all of the following hold:
  - row ≥ K-1 and col ≥ K-1
  - (row-(K-1)) mod STRIDE == 0
  - (col-(K-1)) mod STRIDE == 0
  - Implement the modulo checks with per-axis phase bits, not dividers.
- FSM:
  - IDLE: counters at 0. Goes to ACTIVE on the first step.
  - ACTIVE: goes to DONE on the step at (PW-1, PH-1).
  - DONE: one cycle; frame_done=1, no step. Returns to IDLE.
- Shift register content is kept across frames. The first K-1 padded rows never produce windows, so stale data never reaches win_data.
- Output count per frame: ((PH-K)/STRIDE+1)·((PW-K)/STRIDE+1).

## Timing
- Reset values:
  - state=IDLE, row=col=0, shreg all 0
  - win_data=0, win_valid=0, frame_done=0
  - in_ready = !padding(0,0), i.e. 0 when PAD>0
- Latency: win_valid rises the cycle after the step that shifts in the window's bottom-right pixel.
- win_valid update:
  - Set on a window-producing step.
  - Cleared on a handshake (win_valid && win_ready) with no new window in that cycle.
  - Stays 1 if a new window is produced in the handshake cycle (back-to-back, 1 window/clk).
- While win_valid && !win_ready:
  - No step, in_ready=0.
  - win_data and win_valid are held stable.
  - Counters are frozen.
- Throughput: one padded position per clock with in_valid=1 and win_ready=1. A frame takes PW·PH+1 cycles including DONE.
- in_valid bubbles stall only at real positions; padding positions proceed without input.
- frame_done is asserted in the cycle after the last step. It may coincide with win_valid for the final window.
- Asynchronous reset mid-frame returns everything to reset values immediately. The next accepted pixel is treated as pixel (0,0) of a new frame.

## Test plan
- IMG 4×4, K=3, PAD=1, STRIDE=1, pixels 1..16, in_valid=1, win_ready=1:
  - 16 windows.
  - First window = [0,0,0, 0,1,2, 0,5,6].
  - Last window = [11,12,0, 15,16,0, 0,0,0].
  - frame_done at cycle 37.
- Same setup, STRIDE=2:
  - 4 windows.
  - Second window = [0,0,0, 2,3,4, 6,7,8].
  - No win_valid for odd positions.
- IMG 4×4, K=3, PAD=0:
  - in_ready=1 from reset.
  - 4 windows; first = [1,2,3, 5,6,7, 9,10,11].
- Backpressure: win_ready low 5 cycles on the third window.
  - win_data and win_valid are held.
  - in_ready=0 throughout.
  - No pixel is lost; window sequence is identical to the no-stall run.
- in_valid random 50%: window sequence is identical to the first scenario; padding positions advance without input.
- Reset asserted after pixel 7:
  - All outputs return to reset values.
  - The following 16-pixel frame reproduces the first scenario exactly.
  - Two consecutive frames produce identical window sets.

Source files
------------

// File: rtl/line_window_gen_if.sv
// Pixel-in / window-out handshake bundle for line_window_gen.
// master = pixel source and window sink; slave = the window generator.
interface line_window_gen_if #(
    parameter int DATA_W = 14,
    parameter int K      = 3
);
    logic [DATA_W-1:0]       in_pixel;
    logic                    in_valid;
    logic                    in_ready;
    logic [DATA_W*K*K-1:0]   win_data;
    logic                    win_valid;
    logic                    win_ready;
    logic                    frame_done;

    modport master (
        output in_pixel, in_valid, win_ready,
        input  in_ready, win_data, win_valid, frame_done
    );

    modport slave (
        input  in_pixel, in_valid, win_ready,
        output in_ready, win_data, win_valid, frame_done
    );
endinterface

// File: rtl/line_window_gen.sv
// Sliding KxK window generator with internal zero padding, stride selection
// and valid/ready flow control on both the pixel and the window side.
module line_window_gen #(
    parameter int IMG_W  = 224,
    parameter int IMG_H  = 224,
    parameter int K      = 3,
    parameter int PAD    = 1,
    parameter int STRIDE = 1,
    parameter int DATA_W = 14
) (
    input  logic              clk,
    input  logic              rst,
    line_window_gen_if.slave  bus
);
    localparam int PW    = IMG_W + 2 * PAD;
    localparam int PH    = IMG_H + 2 * PAD;
    localparam int DEPTH = (K - 1) * PW + K;
    localparam int COL_W = $clog2(PW);
    localparam int ROW_W = $clog2(PH);

    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

    state_t            state, state_nxt;
    logic [COL_W-1:0]  col, col_nxt;
    logic [ROW_W-1:0]  row, row_nxt;
    logic              col_ph, col_ph_nxt;
    logic              row_ph, row_ph_nxt;
    logic              win_valid_q, win_valid_nxt;
    logic [DATA_W-1:0] shreg [DEPTH];

    logic pad_pos;
    logic advance;
    logic step;
    logic col_end;
    logic last_pos;
    logic win_hit;

    always_comb begin
        state_nxt     = state;
        col_nxt       = col;
        row_nxt       = row;
        col_ph_nxt    = col_ph;
        row_ph_nxt    = row_ph;
        win_valid_nxt = win_valid_q;

        pad_pos  = (int'(col) < PAD) || (int'(col) >= PAD + IMG_W) ||
                   (int'(row) < PAD) || (int'(row) >= PAD + IMG_H);
        advance  = !(win_valid_q && !bus.win_ready);
        step     = advance && (state != DONE) && (pad_pos || bus.in_valid);
        col_end  = (int'(col) == PW - 1);
        last_pos = col_end && (int'(row) == PH - 1);
        // K-1 is even, so coordinate parity equals parity of (coord-(K-1))
        win_hit  = (int'(row) >= K - 1) && (int'(col) >= K - 1) &&
                   ((STRIDE == 1) || (!row_ph && !col_ph));

        bus.in_ready = advance && !pad_pos && (state != DONE);

        if (win_valid_q && bus.win_ready) win_valid_nxt = 1'b0;
        if (step && win_hit)              win_valid_nxt = 1'b1;

        if (step) begin
            if (col_end) begin
                col_nxt    = '0;
                col_ph_nxt = 1'b0;
                if (last_pos) begin
                    row_nxt    = '0;
                    row_ph_nxt = 1'b0;
                end else begin
                    row_nxt    = row + 1'b1;
                    row_ph_nxt = !row_ph;
                end
            end else begin
                col_nxt    = col + 1'b1;
                col_ph_nxt = !col_ph;
            end
        end

        case (state)
            IDLE, ACTIVE: begin
                if (step && last_pos) state_nxt = DONE;
                else if (step)        state_nxt = ACTIVE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            col         <= '0;
            row         <= '0;
            col_ph      <= 1'b0;
            row_ph      <= 1'b0;
            win_valid_q <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) shreg[i] <= '0;
        end else begin
            state       <= state_nxt;
            col         <= col_nxt;
            row         <= row_nxt;
            col_ph      <= col_ph_nxt;
            row_ph      <= row_ph_nxt;
            win_valid_q <= win_valid_nxt;
            if (step) begin
                shreg[0] <= pad_pos ? '0 : bus.in_pixel;
                for (int unsigned i = 1; i < DEPTH; i++) shreg[i] <= shreg[i-1];
            end
        end
    end

    always_comb begin
        bus.win_data = '0;
        for (int unsigned r = 0; r < K; r++) begin
            for (int unsigned c = 0; c < K; c++) begin
                bus.win_data[DATA_W*(r*K+c) +: DATA_W] = shreg[(K-1-r)*PW + (K-1-c)];
            end
        end
    end

    assign bus.win_valid  = win_valid_q;
    assign bus.frame_done = (state == DONE);

endmodule

// File: tb/tb_line_window_gen.sv
// Scoreboard bench for line_window_gen on a 4x4 image: three instances
// (PAD1/STRIDE1, PAD1/STRIDE2, PAD0/STRIDE1), each held in reset until used.
module tb_line_window_gen;
    localparam int DW = 14;
    localparam int KK = 3;
    localparam int WW = DW * KK * KK;
    typedef logic [WW-1:0] win_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst [3];
    logic [DW-1:0] px  [3];
    logic          iv  [3];
    logic          wr  [3];
    logic          ir  [3];
    logic          wv  [3];
    logic          fd  [3];
    win_t          wd  [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        line_window_gen_if #(.DATA_W(DW), .K(KK)) bus ();
        assign bus.in_pixel  = px[g];
        assign bus.in_valid  = iv[g];
        assign bus.win_ready = wr[g];
        assign ir[g] = bus.in_ready;
        assign wv[g] = bus.win_valid;
        assign wd[g] = bus.win_data;
        assign fd[g] = bus.frame_done;
        line_window_gen #(
            .IMG_W(4), .IMG_H(4), .K(KK),
            .PAD((g == 2) ? 0 : 1), .STRIDE((g == 1) ? 2 : 1), .DATA_W(DW)
        ) dut (
            .clk(clk),
            .rst(rst[g]),
            .bus(bus)
        );
    end

    int   n_vec  = 0;
    int   n_err  = 0;
    int   hs_cnt = 0;
    int   cyc    = 0;
    win_t sbq [$];
    win_t mon_exp;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input win_t act, input win_t exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every presented-and-accepted window is popped against the scoreboard.
    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (wv[g] === 1'b1 && wr[g] === 1'b1) begin
                hs_cnt++;
                if (sbq.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL win_extra: dut%0d got %h expected none", g, wd[g]);
                end else begin
                    mon_exp = sbq.pop_front();
                    chk($sformatf("window dut%0d", g), wd[g], mon_exp);
                end
            end
        end
    end

    function automatic win_t pack9(input int v [9]);
        win_t w = '0;
        for (int i = 0; i < 9; i++) w[DW*i +: DW] = DW'(v[i]);
        return w;
    endfunction

    // Reference: index the padded 4x4 image directly at the window's top-left corner.
    function automatic win_t model(input int pad, input int s, input int oy, input int ox);
        win_t w = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                int y = oy * s + r;
                int x = ox * s + c;
                int v = (y < pad || y >= pad + 4 || x < pad || x >= pad + 4) ? 0
                        : (y - pad) * 4 + (x - pad) + 1;
                w[DW*(r*3+c) +: DW] = DW'(v);
            end
        end
        return w;
    endfunction

    task automatic push_frame(input int pad, input int s);
        int n = (4 + 2 * pad - 3) / s + 1;
        for (int oy = 0; oy < n; oy++)
            for (int ox = 0; ox < n; ox++)
                sbq.push_back(model(pad, s, oy, ox));
    endtask

    task automatic step_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int g, input int v);
        logic acc;
        px[g] = DW'(v);
        iv[g] = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            acc = ir[g];
            @(posedge clk);
            #1;
            if (acc) return;
        end
        n_vec++;
        n_err++;
        $display("FAIL send_timeout: dut%0d pixel %0d not accepted, required acceptance", g, v);
    endtask

    task automatic send_frame(input int g, input bit bubbles);
        for (int p = 1; p <= 16; p++) begin
            if (bubbles) begin
                while ($urandom_range(0, 1) == 1) begin
                    iv[g] = 1'b0;
                    step_cyc();
                end
            end
            send(g, p);
        end
        iv[g] = 1'b0;
    endtask

    task automatic wait_done(input int g, output int at);
        at = -1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (fd[g]) begin
                at = cyc;
                @(negedge clk);
                chk("frame_done_pulse_width", win_t'(fd[g]), win_t'(0));
                step_cyc();
                return;
            end
        end
        n_vec++;
        n_err++;
        $display("FAIL frame_done_timeout: dut%0d got no pulse, required one", g);
    endtask

    task automatic restart(input int g);
        rst[g] = 1'b0;
        step_cyc();
        step_cyc();
        rst[g] = 1'b1;
    endtask

    int   t0, at, base, base_hs;
    win_t w_first, w_last, w_s2b, w_p0;

    initial begin
        w_first = pack9('{0, 0, 0, 0, 1, 2, 0, 5, 6});
        w_last  = pack9('{11, 12, 0, 15, 16, 0, 0, 0, 0});
        w_s2b   = pack9('{0, 0, 0, 2, 3, 4, 6, 7, 8});
        w_p0    = pack9('{1, 2, 3, 5, 6, 7, 9, 10, 11});
        for (int g = 0; g < 3; g++) begin
            rst[g] = 1'b0;
            px[g]  = '0;
            iv[g]  = 1'b0;
            wr[g]  = 1'b1;
        end
        repeat (3) step_cyc();

        chk("rst_win_valid", win_t'(wv[0]), win_t'(0));
        chk("rst_win_data", wd[0], '0);
        chk("rst_frame_done", win_t'(fd[0]), win_t'(0));
        chk("rst_in_ready_pad1", win_t'(ir[0]), win_t'(0));
        chk("rst_in_ready_pad0", win_t'(ir[2]), win_t'(1));

        // Full-rate stride-1 frame.
        rst[0] = 1'b1;
        t0 = cyc;
        base = sbq.size();
        push_frame(1, 1);
        sbq[base]      = w_first;
        sbq[base + 15] = w_last;
        send_frame(0, 1'b0);
        wait_done(0, at);
        chk("frame_done_cycle", win_t'(at - t0 + 1), win_t'(37));
        repeat (2) step_cyc();
        chk("s1_window_count", win_t'(sbq.size()), win_t'(0));

        // Backpressure on the third window.
        restart(0);
        base = sbq.size();
        push_frame(1, 1);
        sbq[base + 2] = w_s2b;
        base_hs = hs_cnt;
        fork
            send_frame(0, 1'b0);
            begin : stall
                int t;
                t = 0;
                while (hs_cnt - base_hs < 2 && t < 300) begin
                    @(posedge clk);
                    #1;
                    t++;
                end
                wr[0] = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    chk("stall_win_valid", win_t'(wv[0]), win_t'(1));
                    chk("stall_win_data", wd[0], w_s2b);
                    chk("stall_in_ready", win_t'(ir[0]), win_t'(0));
                end
                @(posedge clk);
                #1;
                wr[0] = 1'b1;
            end
        join
        wait_done(0, at);
        repeat (2) step_cyc();
        chk("stall_window_count", win_t'(sbq.size()), win_t'(0));

        // Random input bubbles; padding must advance without input.
        restart(0);
        push_frame(1, 1);
        repeat (10) step_cyc();
        chk("pad_advance_in_ready", win_t'(ir[0]), win_t'(1));
        send_frame(0, 1'b1);
        wait_done(0, at);
        repeat (2) step_cyc();
        chk("bubble_window_count", win_t'(sbq.size()), win_t'(0));

        // Asynchronous reset after pixel 7, then two clean frames.
        restart(0);
        sbq.push_back(w_first);
        for (int p = 1; p <= 7; p++) send(0, p);
        rst[0] = 1'b0;
        #1;
        chk("mid_rst_win_valid", win_t'(wv[0]), win_t'(0));
        chk("mid_rst_win_data", wd[0], '0);
        chk("mid_rst_frame_done", win_t'(fd[0]), win_t'(0));
        chk("mid_rst_in_ready", win_t'(ir[0]), win_t'(0));
        chk("mid_rst_queue", win_t'(sbq.size()), win_t'(0));
        iv[0] = 1'b0;
        step_cyc();
        rst[0] = 1'b1;
        push_frame(1, 1);
        push_frame(1, 1);
        send_frame(0, 1'b0);
        send_frame(0, 1'b0);
        wait_done(0, at);
        repeat (2) step_cyc();
        chk("two_frame_window_count", win_t'(sbq.size()), win_t'(0));
        rst[0] = 1'b0;

        // Stride 2.
        rst[1] = 1'b1;
        base = sbq.size();
        push_frame(1, 2);
        sbq[base + 1] = w_s2b;
        send_frame(1, 1'b0);
        wait_done(1, at);
        repeat (2) step_cyc();
        chk("s2_window_count", win_t'(sbq.size()), win_t'(0));

        // No padding.
        rst[2] = 1'b1;
        base = sbq.size();
        push_frame(0, 1);
        sbq[base] = w_p0;
        send_frame(2, 1'b0);
        wait_done(2, at);
        repeat (2) step_cyc();
        chk("pad0_window_count", win_t'(sbq.size()), win_t'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
